scmp_op_dispatch: RTL

//  Opcode dispatch queue between instruction-byte fetch and the microcode sequencer.

---
 rtl/scmp_op_dispatch.sv | 111 +++++++++++
 1 files changed

// File: rtl/scmp_op_dispatch.sv
// scmp_op_dispatch: byte-stream to instruction-record dispatch FIFO; `SCMP_OP_DISPATCH_STATS_EN enables the FETCH-dispatch counter
package scmp_op_dispatch_pkg;
  typedef enum logic [3:0] {
    UCLBL_FETCH, UCLBL_XAE, UCLBL_ST, UCLBL_LD, UCLBL_LDE,
    UCLBL_ILD, UCLBL_DLD, UCLBL_JMP, UCLBL_XPAL, UCLBL_XPAH
  } NEXTPC_t;
endpackage

module scmp_op_dispatch
  import scmp_op_dispatch_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int UNDEF_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       dq_valid,
  input  logic                       dq_ready,
  output logic [7:0]                 dq_op,
  output logic [7:0]                 dq_disp,
  output logic                       dq_2byte,
  output NEXTPC_t                    dq_pc,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [UNDEF_CNT_W-1:0]     undef_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic {S_OP, S_DISP} state_t;

  state_t        state;
  logic [7:0]    op_q;
  logic [7:0]    mem_op   [DEPTH];
  logic [7:0]    mem_disp [DEPTH];
  NEXTPC_t       mem_pc   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          full, acc, push, pop;
  logic [7:0]    rec_op, rec_disp;
  NEXTPC_t       rec_pc;

  assign full     = count == LW'(DEPTH);
  assign in_ready = !full;
  assign acc      = in_valid && !full;
  assign push     = acc && (state == S_DISP || !in_data[7]);
  assign pop      = dq_ready && count != '0;
  assign rec_op   = state == S_DISP ? op_q : in_data;
  assign rec_disp = state == S_DISP ? in_data : 8'h00;

  // first-match decode; CC (immediate) deliberately falls through ST to LD
  always_comb begin
    rec_pc = UCLBL_FETCH;
    casez (rec_op)
      8'b0000_0001: rec_pc = UCLBL_XAE;
      8'b1100_1100: rec_pc = UCLBL_LD;
      8'b1100_1???: rec_pc = UCLBL_ST;
      8'b11??_????: rec_pc = UCLBL_LD;
      8'b01??_?000: rec_pc = UCLBL_LDE;
      8'b1010_10??: rec_pc = UCLBL_ILD;
      8'b1011_10??: rec_pc = UCLBL_DLD;
      8'b1001_????: rec_pc = UCLBL_JMP;
      8'b0011_00??: rec_pc = UCLBL_XPAL;
      8'b0011_01??: rec_pc = UCLBL_XPAH;
      default:      rec_pc = UCLBL_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= S_OP;
      op_q   <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc) state <= state == S_OP && in_data[7] ? S_DISP : S_OP;
      if (acc && state == S_OP) op_q <= in_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= rec_op;
      mem_disp[wr_ptr] <= rec_disp;
      mem_pc[wr_ptr]   <= rec_pc;
    end
  end

  assign dq_valid = count != '0;
  assign dq_op    = mem_op[rd_ptr];
  assign dq_disp  = mem_disp[rd_ptr];
  assign dq_pc    = mem_pc[rd_ptr];
  assign dq_2byte = dq_op[7];
  assign level    = count;

`ifdef SCMP_OP_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) undef_cnt <= '0;
    else if (push && !flush && rec_pc == UCLBL_FETCH && !(&undef_cnt)) undef_cnt <= undef_cnt + 1'b1;
  end
`else
  assign undef_cnt = '0;
`endif
endmodule
